charlieplex_scanner: RTL and testbench

Scans a charlieplexed switch matrix of PINCOUNT*(PINCOUNT-1) diode-isolated keys through PINCOUNT tristateable pins. Each pin in turn is driven low while the others float on external pull-ups. Sampled levels are assembled into a per-frame key bitmap. Key numbering is row-major, skipping the diagonal, so LED and key indices coincide on shared boards. Output goes to the application logic.

---
 rtl/charlieplex_scanner.sv | 142 ++++++++++++++
 tb/tb_charlieplex_scanner.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/charlieplex_scanner.sv
// Charlieplexed key-matrix scanner: row drive, 2-FF sync, frame commit.
// Optional per-key debounce when CHARLIEPLEX_SCANNER_DEBOUNCE_EN is defined.
module charlieplex_scanner #(
  parameter int PINCOUNT = 4,
  parameter int SETTLE   = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             enable,
  input  logic [PINCOUNT-1:0]              pin_in,
  output logic [PINCOUNT-1:0]              out_en,
  output logic [PINCOUNT-1:0]              out_value,
  output logic [PINCOUNT*(PINCOUNT-1)-1:0] keys,
  output logic                             frame_done,
  output logic                             changed
);

  localparam int NK = PINCOUNT * (PINCOUNT - 1);
  localparam int RW = (PINCOUNT > 2) ? $clog2(PINCOUNT) : 1;
  localparam int CW = $clog2(SETTLE);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    GAP,
    COMMIT
  } state_t;

  state_t state, state_n;
  logic [RW-1:0] row, row_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [PINCOUNT-1:0] sync1, sync2;
  logic [NK-1:0] raw, raw_n, keys_n;
  logic commit;

  assign out_value = '0;
  assign commit = (state == COMMIT) && enable;

  always_comb begin
    out_en = '0;
    if (state == DRIVE) out_en[row] = 1'b1;
  end

  always_comb begin
    state_n = state;
    row_n   = row;
    cnt_n   = cnt;
    raw_n   = raw;
    unique case (state)
      IDLE: begin
        if (enable) begin
          state_n = DRIVE;
          row_n   = '0;
          cnt_n   = '0;
        end
      end
      DRIVE: begin
        if (cnt == CW'(SETTLE - 1)) begin
          state_n = GAP;
          for (int y = 0; y < PINCOUNT; y++)
            for (int x = 0; x < PINCOUNT; x++)
              if (x != y && row == RW'(y))
                raw_n[y*(PINCOUNT-1) + ((x < y) ? x : x - 1)] = ~sync2[x];
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      GAP: begin
        if (row == RW'(PINCOUNT - 1)) begin
          state_n = COMMIT;
        end else begin
          state_n = DRIVE;
          row_n   = row + 1'b1;
          cnt_n   = '0;
        end
      end
      COMMIT: begin
        state_n = DRIVE;
        row_n   = '0;
        cnt_n   = '0;
      end
    endcase
    // Abort: partial frame is thrown away, committed keys untouched.
    if (!enable) begin
      state_n = IDLE;
      row_n   = '0;
      cnt_n   = '0;
      raw_n   = '0;
    end
  end

`ifdef CHARLIEPLEX_SCANNER_DEBOUNCE_EN
  logic [1:0] dcnt [NK];
  logic [1:0] dcnt_n [NK];

  always_comb begin
    keys_n = keys;
    for (int k = 0; k < NK; k++) begin
      dcnt_n[k] = '0;
      if (raw[k] != keys[k]) begin
        if (dcnt[k] == 2'd2) keys_n[k] = ~keys[k];
        else dcnt_n[k] = dcnt[k] + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NK; k++) dcnt[k] <= '0;
    end else if (commit) begin
      for (int k = 0; k < NK; k++) dcnt[k] <= dcnt_n[k];
    end
  end
`else
  assign keys_n = raw;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      row        <= '0;
      cnt        <= '0;
      sync1      <= '1;
      sync2      <= '1;
      raw        <= '0;
      keys       <= '0;
      frame_done <= 1'b0;
      changed    <= 1'b0;
    end else begin
      state      <= state_n;
      row        <= row_n;
      cnt        <= cnt_n;
      sync1      <= pin_in;
      sync2      <= sync1;
      raw        <= raw_n;
      frame_done <= commit;
      changed    <= commit && (keys_n != keys);
      if (commit) keys <= keys_n;
    end
  end

endmodule

// File: tb/tb_charlieplex_scanner.sv
// Randomized bench for charlieplex_scanner with a physical pad model
// and a frame-level reference model of committed key state.
module tb_charlieplex_scanner;

  localparam int P     = 4;
  localparam int S     = 4;
  localparam int NK    = P * (P - 1);
  localparam int FRAME = P * (S + 1) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [P-1:0]  pin_in;
  logic [P-1:0]  out_en;
  logic [P-1:0]  out_value;
  logic [NK-1:0] keys;
  logic          frame_done;
  logic          changed;

  always #5 clk = ~clk;

  charlieplex_scanner #(.PINCOUNT(P), .SETTLE(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .pin_in    (pin_in),
    .out_en    (out_en),
    .out_value (out_value),
    .keys      (keys),
    .frame_done(frame_done),
    .changed   (changed)
  );

  logic [NK-1:0] pressed;
  logic [NK-1:0] m_keys;
  logic          m_changed;
  int            streak [NK];
  int            total;
  int            passed;
  bit            ac;
  bit            ab;

  function automatic int kidx(int x, int y);
    return y * (P - 1) + ((x < y) ? x : x - 1);
  endfunction

  // Pads float high; a driven pin reads low, and a pressed key (x,y)
  // pulls anode x low through its diode when cathode y is driven.
  function automatic logic [P-1:0] pads(logic [P-1:0] en, logic [NK-1:0] pr);
    logic [P-1:0] v;
    v = '1;
    for (int x = 0; x < P; x++) begin
      if (en[x]) v[x] = 1'b0;
      for (int y = 0; y < P; y++)
        if (y != x && en[y] && pr[kidx(x, y)]) v[x] = 1'b0;
    end
    return v;
  endfunction

  assign pin_in = pads(out_en, pressed);

  function automatic logic [P-1:0] exp_en(int p);
    if (p >= P * (S + 1)) return '0;
    if (p % (S + 1) == S) return '0;
    return P'(1) << (p / (S + 1));
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_keys    = '0;
    m_changed = 1'b0;
    for (int k = 0; k < NK; k++) streak[k] = 0;
  endtask

  task automatic model_commit();
    logic [NK-1:0] nk;
`ifdef CHARLIEPLEX_SCANNER_DEBOUNCE_EN
    nk = m_keys;
    for (int k = 0; k < NK; k++) begin
      if (pressed[k] != m_keys[k]) begin
        streak[k]++;
        if (streak[k] == 3) begin
          nk[k]     = ~m_keys[k];
          streak[k] = 0;
        end
      end else begin
        streak[k] = 0;
      end
    end
`else
    nk = pressed;
`endif
    m_changed = (nk != m_keys);
    m_keys    = nk;
  endtask

  task automatic pick_pressed(int force_pr);
    if (force_pr >= 0) begin
      pressed = force_pr[NK-1:0];
      return;
    end
    case ($urandom_range(0, 3))
      0: pressed = pressed;
      1: pressed = '0;
      2: pressed = NK'($urandom & $urandom);
      default: pressed = NK'(1) << $urandom_range(0, NK - 1);
    endcase
  endtask

  // Entered at frame position 0 (row 0, first drive cycle).
  task automatic run_frame(input bit after, input int abort_at,
                           input int force_pr, output bit aborted);
    aborted = 1'b0;
    for (int p = 0; p < FRAME; p++) begin
      check("out_en", 32'(out_en), 32'(exp_en(p)));
      check("out_value", 32'(out_value), 32'd0);
      if (p == 0 && after) begin
        check("frame_done", 32'(frame_done), 32'd1);
        check("keys_commit", 32'(keys), 32'(m_keys));
        check("changed", 32'(changed), 32'(m_changed));
      end else begin
        check("frame_done_idle", 32'(frame_done), 32'd0);
        check("changed_idle", 32'(changed), 32'd0);
        check("keys_hold", 32'(keys), 32'(m_keys));
      end
      if (p == 0) pick_pressed(force_pr);
      if (p == abort_at) begin
        enable = 1'b0;
        tick();
        check("abort_out_en", 32'(out_en), 32'd0);
        check("abort_no_done", 32'(frame_done), 32'd0);
        repeat ($urandom_range(1, 4)) begin
          tick();
          check("idle_out_en", 32'(out_en), 32'd0);
          check("idle_no_done", 32'(frame_done), 32'd0);
          check("idle_keys", 32'(keys), 32'(m_keys));
        end
        enable = 1'b1;
        tick();
        aborted = 1'b1;
        return;
      end
      tick();
    end
    model_commit();
  endtask

  initial begin
    total   = 0;
    passed  = 0;
    rst     = 1'b1;
    enable  = 1'b0;
    pressed = '0;
    model_reset();
    repeat (3) tick();
    check("rst_out_en", 32'(out_en), 32'd0);
    check("rst_out_value", 32'(out_value), 32'd0);
    check("rst_keys", 32'(keys), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_changed", 32'(changed), 32'd0);
    rst = 1'b0;
    tick();
    check("idle_en", 32'(out_en), 32'd0);
    enable = 1'b1;
    tick();
    ac = 1'b0;

    run_frame(ac, -1, 12'h000, ab); ac = !ab;
    run_frame(ac, -1, 12'h000, ab); ac = !ab;
    run_frame(ac, -1, 12'h020, ab); ac = !ab;
    run_frame(ac, -1, 12'h020, ab); ac = !ab;
    run_frame(ac, -1, 12'h801, ab); ac = !ab;
    run_frame(ac, -1, 12'h000, ab); ac = !ab;
    run_frame(ac, -1, 12'h000, ab); ac = !ab;
    run_frame(ac, 12, 12'h020, ab); ac = !ab;

    run_frame(ac, -1, 12'h020, ab); ac = !ab;
    run_frame(ac, -1, 12'h020, ab); ac = !ab;
    run_frame(ac, -1, 12'h000, ab); ac = !ab;
    run_frame(ac, -1, 12'h020, ab); ac = !ab;
    run_frame(ac, -1, 12'h020, ab); ac = !ab;
    run_frame(ac, -1, 12'h020, ab); ac = !ab;
    run_frame(ac, -1, 12'h020, ab); ac = !ab;

    for (int i = 0; i < 40; i++) begin
      int ab_at;
      ab_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, FRAME - 1)) : -1;
      run_frame(ac, ab_at, -1, ab);
      ac = !ab;
    end

    run_frame(ac, -1, 12'h020, ab); ac = !ab;
    run_frame(ac, -1, 12'h020, ab); ac = !ab;
    run_frame(ac, -1, 12'h020, ab); ac = !ab;
    run_frame(ac, -1, 12'h020, ab); ac = !ab;
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("mid_rst_keys", 32'(keys), 32'd0);
    check("mid_rst_out_en", 32'(out_en), 32'd0);
    check("mid_rst_done", 32'(frame_done), 32'd0);
    check("mid_rst_changed", 32'(changed), 32'd0);
    model_reset();
    rst = 1'b0;
    tick();
    ac = 1'b0;
    run_frame(ac, -1, 12'h020, ab); ac = !ab;
    run_frame(ac, -1, -1, ab); ac = !ab;

    if (ac) begin
      check("final_done", 32'(frame_done), 32'd1);
      check("final_keys", 32'(keys), 32'(m_keys));
      check("final_changed", 32'(changed), 32'(m_changed));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
